// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI-slave write decoder owning the five PWM configuration registers
module spi_reg_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_copi_sync, r_ncs_sync;
  logic r_sclk_d, r_ncs_d;
  logic [15:0] r_shift;
  logic [4:0] r_cnt;
  logic [7:0] r_regs [5];
  logic r_wr, r_err;
  logic w_sclk_rise, w_ncs_rise, w_ncs_fall, w_copi, w_valid;
  logic w_clr, w_shift, w_commit, w_err;
  assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_d;
  assign w_ncs_rise  = r_ncs_sync[SYNC_STAGES-1] & ~r_ncs_d;
  assign w_ncs_fall  = ~r_ncs_sync[SYNC_STAGES-1] & r_ncs_d;
  assign w_copi      = r_copi_sync[SYNC_STAGES-1];
  assign w_valid     = (r_cnt == 5'd16) && r_shift[15] && (r_shift[14:8] <= 7'(MAX_ADDR));
  // Synchronizers start at idle bus levels so reset release never fakes an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_copi_sync <= '0;
      r_ncs_sync  <= '1;
      r_sclk_d    <= 1'b0;
      r_ncs_d     <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_ncs_d     <= r_ncs_sync[SYNC_STAGES-1];
    end
  end
  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // Next state and datapath controls; ncs rise wins over a coincident sclk rise
  always_comb begin
    w_next   = r_state;
    w_clr    = 1'b0;
    w_shift  = 1'b0;
    w_commit = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      IDLE: begin
        w_next = w_ncs_fall ? SHIFT : IDLE;
        w_clr  = w_ncs_fall;
      end
      SHIFT: begin
        w_next  = w_ncs_rise ? (w_valid ? COMMIT : IDLE) : SHIFT;
        w_err   = w_ncs_rise & ~w_valid;
        w_shift = ~w_ncs_rise & w_sclk_rise;
      end
      COMMIT: begin
        w_commit = 1'b1;
        w_next   = w_ncs_fall ? SHIFT : IDLE;
        w_clr    = w_ncs_fall;
      end
      default: w_next = IDLE;
    endcase
  end
  // Shift register, saturating bit counter, register file and strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      for (int i = 0; i < 5; i++) r_regs[i] <= '0;
    end else begin
      r_wr  <= w_commit;
      r_err <= w_err;
      if (w_clr) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else if (w_shift) begin
        r_shift <= {r_shift[14:0], w_copi};
        r_cnt   <= (r_cnt == 5'd17) ? 5'd17 : r_cnt + 5'd1;
      end
      for (int i = 0; i < 5; i++)
        if (w_commit && r_shift[14:8] == 7'(i)) r_regs[i] <= r_shift[7:0];
    end
  end
  assign en_reg_out_7_0  = r_regs[0];
  assign en_reg_out_15_8 = r_regs[1];
  assign en_reg_pwm_7_0  = r_regs[2];
  assign en_reg_pwm_15_8 = r_regs[3];
  assign pwm_duty_cycle  = r_regs[4];
  assign wr_strobe       = r_wr;
  assign frame_err       = r_err;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed scenario tests for the SPI register controller
module tb_spi_reg_ctrl;
  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic wr_strobe, frame_err;
  int errors = 0, checks = 0, wr_cnt = 0, err_cnt = 0;
  logic [39:0] regs_all;

  spi_reg_ctrl dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  assign regs_all = {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};

  always #5 clk = ~clk;

  // count strobe-high cycles, sampled away from the active edge
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) wr_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // lowers ncs and clocks n bits MSB first (bits past 16 are 0); leaves ncs low
  task automatic shift_frame(input logic [15:0] f, input int n);
    ncs = 1'b0;
    wait_clk(4);
    for (int i = 0; i < n; i++) begin
      copi = (i < 16) ? f[15-i] : 1'b0;
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
    wait_clk(4);
  endtask

  task automatic test_reset;
    int w0, e0;
    wait_clk(3);
    checks++;
    if (regs_all !== 40'h0) begin
      $display("FAIL reset_regs: got %h expected %h", regs_all, 40'h0); errors++;
    end
    checks++;
    if ({wr_strobe, frame_err} !== 2'b00) begin
      $display("FAIL reset_strobes: got %b expected 00", {wr_strobe, frame_err}); errors++;
    end
    rst = 1'b0;
    w0 = wr_cnt; e0 = err_cnt;
    for (int i = 0; i < 20; i++) begin
      copi = i[0];
      sclk = 1'b1; wait_clk(4);
      sclk = 1'b0; wait_clk(4);
    end
    wait_clk(4);
    checks++;
    if (regs_all !== 40'h0) begin
      $display("FAIL idle_sclk_regs: got %h expected %h", regs_all, 40'h0); errors++;
    end
    checks++;
    if (wr_cnt - w0 != 0 || err_cnt - e0 != 0) begin
      $display("FAIL idle_sclk_strobes: got wr=%0d err=%0d expected 0 0", wr_cnt - w0, err_cnt - e0); errors++;
    end
  endtask

  task automatic test_basic_write;
    int w0;
    w0 = wr_cnt;
    shift_frame(16'h8055, 16);
    ncs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (en_reg_out_7_0 !== 8'h00 || wr_strobe !== 1'b0) begin
      $display("FAIL basic_edge3: got reg=%h strobe=%b expected 00 0", en_reg_out_7_0, wr_strobe); errors++;
    end
    @(posedge clk); #1;
    checks++;
    if (en_reg_out_7_0 !== 8'h55 || wr_strobe !== 1'b1) begin
      $display("FAIL basic_edge4: got reg=%h strobe=%b expected 55 1", en_reg_out_7_0, wr_strobe); errors++;
    end
    @(posedge clk); #1;
    checks++;
    if (wr_strobe !== 1'b0) begin
      $display("FAIL basic_edge5_strobe: got %b expected 0", wr_strobe); errors++;
    end
    wait_clk(8);
    checks++;
    if (regs_all !== 40'h5500000000) begin
      $display("FAIL basic_regs: got %h expected %h", regs_all, 40'h5500000000); errors++;
    end
    checks++;
    if (wr_cnt - w0 != 1) begin
      $display("FAIL basic_strobe_count: got %0d expected 1", wr_cnt - w0); errors++;
    end
  endtask

  task automatic test_all_addresses;
    logic [15:0] fr [4];
    int w0;
    fr = '{16'h81F0, 16'h82CC, 16'h8333, 16'h8480};
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      shift_frame(fr[i], 16);
      ncs = 1'b1;
      wait_clk(8);
    end
    checks++;
    if (regs_all !== 40'h55F0CC3380) begin
      $display("FAIL all_addr_regs: got %h expected %h", regs_all, 40'h55F0CC3380); errors++;
    end
    checks++;
    if (wr_cnt - w0 != 4) begin
      $display("FAIL all_addr_strobe_count: got %0d expected 4", wr_cnt - w0); errors++;
    end
  endtask

  task automatic test_rejects;
    logic [15:0] fr [4];
    int nb [4];
    int w0, e0;
    fr = '{16'h0577, 16'h85AA, 16'h8011, 16'h8011};
    nb = '{16, 16, 15, 17};
    for (int i = 0; i < 4; i++) begin
      w0 = wr_cnt; e0 = err_cnt;
      shift_frame(fr[i], nb[i]);
      ncs = 1'b1;
      wait_clk(8);
      checks++;
      if (regs_all !== 40'h55F0CC3380) begin
        $display("FAIL reject%0d_regs: got %h expected %h", i, regs_all, 40'h55F0CC3380); errors++;
      end
      checks++;
      if (err_cnt - e0 != 1 || wr_cnt - w0 != 0) begin
        $display("FAIL reject%0d_strobes: got err=%0d wr=%0d expected 1 0", i, err_cnt - e0, wr_cnt - w0); errors++;
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int w0, e0;
    e0 = err_cnt;
    shift_frame(16'h84FF, 8);
    rst = 1'b1;
    #1;
    checks++;
    if (regs_all !== 40'h0) begin
      $display("FAIL midreset_regs: got %h expected %h", regs_all, 40'h0); errors++;
    end
    wait_clk(2);
    rst = 1'b0;
    ncs = 1'b1;
    wait_clk(8);
    w0 = wr_cnt;
    shift_frame(16'h8440, 16);
    ncs = 1'b1;
    wait_clk(8);
    checks++;
    if (regs_all !== 40'h0000000040) begin
      $display("FAIL midreset_followup_regs: got %h expected %h", regs_all, 40'h0000000040); errors++;
    end
    checks++;
    if (wr_cnt - w0 != 1 || err_cnt - e0 != 0) begin
      $display("FAIL midreset_strobes: got wr=%0d err=%0d expected 1 0", wr_cnt - w0, err_cnt - e0); errors++;
    end
  endtask

  task automatic test_back_to_back;
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    shift_frame(16'h8201, 16);
    ncs = 1'b1;
    wait_clk(1);
    shift_frame(16'h8302, 16);
    ncs = 1'b1;
    wait_clk(8);
    checks++;
    if (regs_all !== 40'h0000010240) begin
      $display("FAIL b2b_regs: got %h expected %h", regs_all, 40'h0000010240); errors++;
    end
    checks++;
    if (wr_cnt - w0 != 2 || err_cnt - e0 != 0) begin
      $display("FAIL b2b_strobes: got wr=%0d err=%0d expected 2 0", wr_cnt - w0, err_cnt - e0); errors++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_all_addresses();
    test_rejects();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
SPI-slave configuration controller that owns the five PWM-peripheral configuration registers: en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle. It samples an external SPI mode-0 bus (SCLK, COPI, nCS) in the system clock domain and decodes 16-bit write frames. Valid frames are committed to the addressed register. The register outputs feed the PWM peripheral directly; a one-cycle strobe flags each commit.

Parameters:
SYNC_STAGES, 2, synchronizer depth applied to sclk, copi and ncs (minimum 2).
MAX_ADDR, 4, highest writable register address; frames addressed above it are discarded.

Ports:
clk  input  1  system clock.
rst  input  1  reset.
sclk  input  1  SPI clock, asynchronous to clk.
copi  input  1  SPI data in, MSB first, sampled on sclk rising edge.
ncs  input  1  SPI chip select, active low.
en_reg_out_7_0  output  8  register 0x00.
en_reg_out_15_8  output  8  register 0x01.
en_reg_pwm_7_0  output  8  register 0x02.
en_reg_pwm_15_8  output  8  register 0x03.
pwm_duty_cycle  output  8  register 0x04.
wr_strobe  output  1  one-cycle pulse in the cycle a register is updated.
frame_err  output  1  one-cycle pulse when a frame is discarded.

Interface decision: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (rst=1, asynchronous assert, released synchronously to clk):
  - All five registers are 0x00.
  - wr_strobe=0, frame_err=0.
  - State is IDLE; shift register and bit counter are cleared.
  - Synchronizer flops reset to idle bus levels: ncs=1, sclk=0, copi=0.
- Synchronization: sclk, copi and ncs each pass through a chain of SYNC_STAGES flops. One further flop per signal holds its previous synchronized value for edge detection. copi uses the same depth as sclk so the two stay aligned.
- Frame format, 16 bits, MSB first:
  - bit15: W (1 = write; 0 = read, which is unsupported and discarded).
  - bits14:8: address, 7 bits.
  - bits7:0: data.
- Bit counter: 5 bits, saturates at 17. A count of 17 marks an overlong frame.
- FSM:
  - IDLE: on synced ncs falling edge, clear the shift register and counter, then go to SHIFT.
  - SHIFT: on each synced sclk rising edge, shift the synced copi into the LSB and increment the counter.
    - On synced ncs rising edge, go to COMMIT if count==16, W==1 and address<=MAX_ADDR.
    - Otherwise on that rising edge, go to IDLE and pulse frame_err for one cycle.
    - A frame with zero bits (ncs low then high with no sclk edges) also pulses frame_err.
  - COMMIT (lasts exactly 1 cycle): write data to the addressed register, pulse wr_strobe, then go to IDLE.
    - If a synced ncs falling edge occurs in the COMMIT cycle, the write still completes and the next state is SHIFT with the counter cleared.
- sclk edges while ncs is high (IDLE) are ignored.
- Latency: counting the first clk edge that samples ncs high as edge 1:
  - The FSM enters COMMIT at edge SYNC_STAGES+1.
  - The register output and wr_strobe update at edge SYNC_STAGES+2, which is edge 4 at the default depth.
- Bus timing requirement: sclk high and low phases are each at least SYNC_STAGES+1 clk periods. ncs high between frames is at least SYNC_STAGES+2 clk periods. Faster buses are out of contract.
- Writes are atomic: a discarded frame never modifies any register. Registers hold their value indefinitely between writes.
- Reset asserted mid-frame: the FSM returns to IDLE immediately and all registers clear. The partial frame is lost. A frame already in progress when reset releases is not decoded, because IDLE waits for a fresh ncs falling edge.

Test Plan:
- Reset: assert rst, check all five registers are 0x00 and both strobes are 0. Release rst, keep ncs=1, toggle sclk 20 times -> registers stay 0x00 and no strobe pulses.
- Basic write: frame 0x8055 (write, address 0x00, data 0x55) -> en_reg_out_7_0=0x55 at edge 4 after ncs rises, wr_strobe high for exactly 1 cycle, other registers unchanged.
- All addresses: write 0xF0 to 0x01, 0xCC to 0x02, 0x33 to 0x03, 0x80 to 0x04, back to back -> each register holds its value and 4 wr_strobe pulses are seen.
- Rejected frames, each leaving all registers unchanged and pulsing frame_err once:
  - 0x0577, a read.
  - 0x85AA, address 0x05 > MAX_ADDR.
  - 0x8011 truncated to 15 bits.
  - 0x8011 followed by 1 extra bit (17 bits).
- Reset mid-frame: after 8 bits of 0x84FF, pulse rst -> registers are 0x00. The frame is not committed, and a following valid frame 0x8440 sets pwm_duty_cycle=0x40.
- Back to back: a second ncs falling edge lands exactly in the COMMIT cycle of frame 0x8201 and carries frame 0x8302 -> en_reg_pwm_7_0=0x01 and en_reg_pwm_15_8=0x02, with 2 wr_strobe pulses.
